// File: rtl/correl_seq_pkg.sv
// Shared types and constants for the correlator frame sequencer: FSM states
// and the bit layout of the FFT/IFFT configuration words.
package correl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_FFT  = 3'd1,
    ST_CFG_IFFT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

  localparam int NFFT_LSB  = 0;
  localparam int NFFT_W    = 5;
  localparam int FWD_BIT   = 8;
  localparam int SCALE_LSB = 9;

  localparam logic FWD = 1'b1;
  localparam logic INV = 1'b0;

endpackage

// File: rtl/correl_ref_ram.sv
// Reference-function store: simple dual-port RAM with synchronous write and a
// registered, enabled read whose output register doubles as the sf data slot.
module correl_ref_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/correl_frame_sequencer.sv
// Configures the FFT/IFFT cores, then streams received samples and matching
// reference samples to the correlator in frame lockstep with tlast.
module correl_frame_sequencer
  import correl_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 10,
  parameter int MIN_LOG2 = 3,
  parameter int SCALE_W  = 14,
  parameter int FRM_W    = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [4:0]          cfg_log2n,
  input  logic [SCALE_W-1:0]  cfg_scale,
  input  logic [FRM_W-1:0]    cfg_frames,
  input  logic                ref_wr_en,
  input  logic [MAX_LOG2-1:0] ref_wr_addr,
  input  logic [2*DATA_W-1:0] ref_wr_data,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [15:0]         fft_cfg_tdata,
  output logic                fft_cfg_tvalid,
  input  logic                fft_cfg_tready,
  output logic [23:0]         ifft_cfg_tdata,
  output logic                ifft_cfg_tvalid,
  input  logic                ifft_cfg_tready,
  output logic [2*DATA_W-1:0] sig_tdata,
  output logic                sig_tvalid,
  output logic                sig_tlast,
  input  logic                sig_tready,
  output logic [2*DATA_W-1:0] sf_tdata,
  output logic                sf_tvalid,
  input  logic                sf_tready,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [FRM_W-1:0]    frame_cnt
);

  localparam int DW2   = 2 * DATA_W;
  localparam int CNT_W = MAX_LOG2 + 1;

  // Handshake rule for every stream here: a beat transfers on a rising edge
  // where valid and ready are both high; valid never waits on ready and, once
  // raised, is held with stable data until that transfer.

  seq_state_e          state_q, state_d;
  logic [NFFT_W-1:0]   log2n_q;
  logic [SCALE_W-1:0]  scale_q;
  logic [FRM_W-1:0]    frames_q;
  logic [FRM_W-1:0]    frame_cnt_q;
  logic                stop_seen_q;
  logic                cfg_err_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, base_cnt, n_len;
  logic                slot_full_q, slot_full_d;
  logic                sig_acc_q, sig_acc_d;
  logic                sf_acc_q, sf_acc_d;
  logic                tlast_q;
  logic [DW2-1:0]      sig_data_q;
  logic [DW2-1:0]      sf_data;

  logic start_acc, start_ok;
  logic up_hs, sig_hs, sf_hs, both_done, frame_end, cont, remaining;
  logic [15:0] fft_word;
  logic [23:0] ifft_word;

  assign start_acc = (state_q == ST_IDLE) && cfg_start;
  assign start_ok  = (cfg_log2n >= NFFT_W'(MIN_LOG2)) && (cfg_log2n <= NFFT_W'(MAX_LOG2));

  assign n_len = CNT_W'(1) << log2n_q;

  assign sig_tvalid = slot_full_q && !sig_acc_q;
  assign sf_tvalid  = slot_full_q && !sf_acc_q;
  assign sig_hs     = sig_tvalid && sig_tready;
  assign sf_hs      = sf_tvalid && sf_tready;
  assign both_done  = slot_full_q && (sig_acc_q || sig_hs) && (sf_acc_q || sf_hs);
  assign frame_end  = both_done && tlast_q;

  // Whether another frame follows the one currently completing.
  assign cont = (frames_q == '0) ? !(stop_seen_q || cfg_stop)
                                 : ((frame_cnt_q + FRM_W'(1)) != frames_q);

  // A completing last beat lets frame k=0 enter in the same cycle.
  assign remaining     = (cnt_q != n_len) || (frame_end && cont);
  assign s_axis_tready = (state_q == ST_STREAM) && remaining && (!slot_full_q || both_done);
  assign up_hs         = s_axis_tvalid && s_axis_tready;

  assign base_cnt = frame_end ? '0 : cnt_q;
  assign cnt_d    = up_hs ? base_cnt + CNT_W'(1) : base_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_acc && start_ok) state_d = ST_CFG_FFT;
      ST_CFG_FFT:  if (fft_cfg_tready)        state_d = ST_CFG_IFFT;
      ST_CFG_IFFT: if (ifft_cfg_tready)       state_d = ST_STREAM;
      ST_STREAM:   if (frame_end && !cont)    state_d = ST_DONE;
      ST_DONE:                                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_full_d = slot_full_q;
    sig_acc_d   = sig_acc_q;
    sf_acc_d    = sf_acc_q;
    if (up_hs) begin
      slot_full_d = 1'b1;
      sig_acc_d   = 1'b0;
      sf_acc_d    = 1'b0;
    end else if (both_done) begin
      slot_full_d = 1'b0;
      sig_acc_d   = 1'b0;
      sf_acc_d    = 1'b0;
    end else begin
      sig_acc_d = sig_acc_q || sig_hs;
      sf_acc_d  = sf_acc_q || sf_hs;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      log2n_q     <= '0;
      scale_q     <= '0;
      frames_q    <= '0;
      frame_cnt_q <= '0;
      stop_seen_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
      slot_full_q <= 1'b0;
      sig_acc_q   <= 1'b0;
      sf_acc_q    <= 1'b0;
      tlast_q     <= 1'b0;
      sig_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_err_q   <= start_acc && !start_ok;
      slot_full_q <= slot_full_d;
      sig_acc_q   <= sig_acc_d;
      sf_acc_q    <= sf_acc_d;
      cnt_q       <= (state_q == ST_STREAM) ? cnt_d : '0;
      if (start_acc) begin
        log2n_q  <= cfg_log2n;
        scale_q  <= cfg_scale;
        frames_q <= cfg_frames;
      end
      if (start_acc && start_ok) frame_cnt_q <= '0;
      else if (frame_end)        frame_cnt_q <= frame_cnt_q + FRM_W'(1);
      if (state_q == ST_IDLE) stop_seen_q <= 1'b0;
      else if (cfg_stop)      stop_seen_q <= 1'b1;
      if (up_hs) begin
        sig_data_q <= s_axis_tdata;
        tlast_q    <= (base_cnt == n_len - CNT_W'(1));
      end
    end
  end

  correl_ref_ram #(
    .AW (MAX_LOG2),
    .DW (DW2)
  ) u_ref_ram (
    .clk_i   (aclk),
    .rst_i   (areset),
    .we_i    (ref_wr_en && (state_q == ST_IDLE)),
    .waddr_i (ref_wr_addr),
    .wdata_i (ref_wr_data),
    .re_i    (up_hs),
    .raddr_i (base_cnt[MAX_LOG2-1:0]),
    .rdata_o (sf_data)
  );

  always_comb begin
    fft_word                         = '0;
    fft_word[NFFT_LSB +: NFFT_W]     = log2n_q;
    fft_word[FWD_BIT]                = FWD;
    ifft_word                        = '0;
    ifft_word[NFFT_LSB +: NFFT_W]    = log2n_q;
    ifft_word[FWD_BIT]               = INV;
    ifft_word[SCALE_LSB +: SCALE_W]  = scale_q;
  end

  assign fft_cfg_tvalid  = (state_q == ST_CFG_FFT);
  assign ifft_cfg_tvalid = (state_q == ST_CFG_IFFT);
  assign fft_cfg_tdata   = fft_cfg_tvalid ? fft_word : '0;
  assign ifft_cfg_tdata  = ifft_cfg_tvalid ? ifft_word : '0;

  assign sig_tdata = sig_data_q;
  assign sig_tlast = tlast_q && sig_tvalid;
  assign sf_tdata  = sf_data;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_correl_frame_sequencer.sv
// Self-checking bench for correl_frame_sequencer: config vector table,
// hand-written corner sequences and randomized runs against a frame model.
module tb_correl_frame_sequencer;

  localparam int DATA_W   = 16;
  localparam int MAX_LOG2 = 10;
  localparam int SCALE_W  = 14;
  localparam int FRM_W    = 16;
  localparam int DW2      = 2 * DATA_W;

  logic                aclk = 1'b0;
  logic                areset;
  logic                cfg_start, cfg_stop;
  logic [4:0]          cfg_log2n;
  logic [SCALE_W-1:0]  cfg_scale;
  logic [FRM_W-1:0]    cfg_frames;
  logic                ref_wr_en;
  logic [MAX_LOG2-1:0] ref_wr_addr;
  logic [DW2-1:0]      ref_wr_data;
  logic [DW2-1:0]      s_axis_tdata;
  logic                s_axis_tvalid, s_axis_tready;
  logic [15:0]         fft_cfg_tdata;
  logic                fft_cfg_tvalid, fft_cfg_tready;
  logic [23:0]         ifft_cfg_tdata;
  logic                ifft_cfg_tvalid, ifft_cfg_tready;
  logic [DW2-1:0]      sig_tdata, sf_tdata;
  logic                sig_tvalid, sig_tlast, sig_tready;
  logic                sf_tvalid, sf_tready;
  logic                busy, done, cfg_err;
  logic [FRM_W-1:0]    frame_cnt;

  correl_frame_sequencer dut (
    .aclk (aclk), .areset (areset),
    .cfg_start (cfg_start), .cfg_stop (cfg_stop), .cfg_log2n (cfg_log2n),
    .cfg_scale (cfg_scale), .cfg_frames (cfg_frames),
    .ref_wr_en (ref_wr_en), .ref_wr_addr (ref_wr_addr), .ref_wr_data (ref_wr_data),
    .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_axis_tready),
    .fft_cfg_tdata (fft_cfg_tdata), .fft_cfg_tvalid (fft_cfg_tvalid), .fft_cfg_tready (fft_cfg_tready),
    .ifft_cfg_tdata (ifft_cfg_tdata), .ifft_cfg_tvalid (ifft_cfg_tvalid), .ifft_cfg_tready (ifft_cfg_tready),
    .sig_tdata (sig_tdata), .sig_tvalid (sig_tvalid), .sig_tlast (sig_tlast), .sig_tready (sig_tready),
    .sf_tdata (sf_tdata), .sf_tvalid (sf_tvalid), .sf_tready (sf_tready),
    .busy (busy), .done (done), .cfg_err (cfg_err), .frame_cnt (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW2-1:0] ref_model [2**MAX_LOG2];
  logic [DW2:0]   exp_sig_q [$];
  logic [DW2-1:0] exp_sf_q  [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cfg_start = 0; cfg_stop = 0; cfg_log2n = '0; cfg_scale = '0; cfg_frames = '0;
    ref_wr_en = 0; ref_wr_addr = '0; ref_wr_data = '0;
    s_axis_tdata = '0; s_axis_tvalid = 0;
    fft_cfg_tready = 0; ifft_cfg_tready = 0; sig_tready = 0; sf_tready = 0;
  endtask

  task automatic load_ram(input bit ramp);
    for (int a = 0; a < 2**MAX_LOG2; a++) begin
      @(negedge aclk);
      ref_wr_en   = 1;
      ref_wr_addr = MAX_LOG2'(a);
      ref_wr_data = ramp ? DW2'(a) : DW2'($urandom);
      ref_model[a] = ref_wr_data;
    end
    @(negedge aclk);
    ref_wr_en = 0;
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    areset = 1;
    idle_inputs();
    @(negedge aclk);
    areset = 0;
  endtask

  // Drive a start, then random config/upstream/downstream traffic until done.
  // Model: the j-th accepted upstream sample pairs with ref[j mod N], tlast on
  // j mod N == N-1; a run ends after the expected number of whole frames.
  task automatic run_stream(input logic [4:0] l2n, input logic [FRM_W-1:0] frm,
                            input int stop_frame, input int p_up, input int p_dn);
    int n_len, exp_frames, stop_at, n_up, k, first_up, last_up;
    bit stop_sent, fft_seen, got_done, up_acc, sig_pend, sf_pend;
    logic [DW2:0]   prev_sig, e_sig;
    logic [DW2-1:0] prev_sf;
    logic [SCALE_W-1:0] scale;
    n_len = 1 << l2n;
    exp_frames = (frm == 0) ? stop_frame : int'(frm);
    stop_at = (stop_frame - 1) * n_len + n_len / 2;
    n_up = 0; first_up = -1; last_up = -1;
    stop_sent = 0; fft_seen = 0; got_done = 0; up_acc = 0; sig_pend = 0; sf_pend = 0;
    prev_sig = '0; prev_sf = '0;
    scale = SCALE_W'($urandom);
    exp_sig_q.delete(); exp_sf_q.delete();
    @(negedge aclk);
    cfg_start = 1; cfg_log2n = l2n; cfg_scale = scale; cfg_frames = frm;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge aclk);
      cfg_start = 0;
      fft_cfg_tready  = 1'($urandom_range(0, 1));
      ifft_cfg_tready = 1'($urandom_range(0, 1));
      sig_tready = ($urandom_range(0, 99) < p_dn);
      sf_tready  = ($urandom_range(0, 99) < p_dn);
      if (up_acc) s_axis_tvalid = 0;
      up_acc = 0;
      if (!s_axis_tvalid && ($urandom_range(0, 99) < p_up)) begin
        s_axis_tvalid = 1;
        s_axis_tdata  = DW2'($urandom);
      end
      cfg_stop = 0;
      if (frm == 0 && !stop_sent && n_up >= stop_at) begin
        cfg_stop = 1;
        stop_sent = 1;
      end
      // RAM writes while busy must not disturb the reference contents.
      ref_wr_en = 1; ref_wr_addr = MAX_LOG2'($urandom); ref_wr_data = DW2'($urandom);
      #1;
      if (ifft_cfg_tvalid) check("ifft_after_fft", fft_seen, 1);
      if (fft_cfg_tvalid && fft_cfg_tready) begin
        check("fft_word", fft_cfg_tdata, 16'h0100 | 16'(l2n));
        fft_seen = 1;
      end
      if (ifft_cfg_tvalid && ifft_cfg_tready)
        check("ifft_word", ifft_cfg_tdata, (24'(scale) << 9) | 24'(l2n));
      if (s_axis_tvalid && s_axis_tready) begin
        k = n_up % n_len;
        exp_sig_q.push_back({k == n_len - 1, s_axis_tdata});
        exp_sf_q.push_back(ref_model[k]);
        if (first_up < 0) first_up = cyc;
        last_up = cyc;
        n_up++;
        up_acc = 1;
      end
      if (sig_pend) check("sig_hold", {sig_tvalid, sig_tlast, sig_tdata}, {1'b1, prev_sig});
      if (sf_pend)  check("sf_hold", {sf_tvalid, sf_tdata}, {1'b1, prev_sf});
      if (sig_tvalid && sig_tready) begin
        check("sig_beat_expected", exp_sig_q.size() != 0, 1);
        if (exp_sig_q.size() != 0) begin
          e_sig = exp_sig_q.pop_front();
          check("sig_beat", {sig_tlast, sig_tdata}, e_sig);
        end
      end
      if (sf_tvalid && sf_tready) begin
        check("sf_beat_expected", exp_sf_q.size() != 0, 1);
        if (exp_sf_q.size() != 0) check("sf_beat", sf_tdata, exp_sf_q.pop_front());
      end
      sig_pend = sig_tvalid && !sig_tready;
      sf_pend  = sf_tvalid && !sf_tready;
      prev_sig = {sig_tlast, sig_tdata};
      prev_sf  = sf_tdata;
      if (done) begin
        got_done = 1;
        ref_wr_en = 0;
      end
    end
    ref_wr_en = 0; cfg_stop = 0; s_axis_tvalid = 0;
    check("done_seen", got_done, 1);
    check("frame_cnt_at_done", frame_cnt, exp_frames);
    check("samples_accepted", n_up, exp_frames * n_len);
    check("queues_drained", exp_sig_q.size() + exp_sf_q.size(), 0);
    if (p_up == 100 && p_dn == 100) check("no_bubble", last_up - first_up, n_up - 1);
    @(negedge aclk);
    #1 check("done_one_cycle", {done, busy}, 2'b00);
  endtask

  // ---------------- config vector table ----------------
  typedef struct {
    logic [4:0]  l2n;
    logic        exp_err;
    logic [15:0] exp_fft;
    int          hold;
  } cfg_vec_t;

  cfg_vec_t vecs[7];
  logic [DW2-1:0] fr_data[8];

  initial begin
    logic [SCALE_W-1:0] sc;
    vecs[0] = '{5'd2,  1'b1, 16'h0000, 0};
    vecs[1] = '{5'd0,  1'b1, 16'h0000, 0};
    vecs[2] = '{5'd11, 1'b1, 16'h0000, 0};
    vecs[3] = '{5'd31, 1'b1, 16'h0000, 0};
    vecs[4] = '{5'd3,  1'b0, 16'h0103, 2};
    vecs[5] = '{5'd10, 1'b0, 16'h010A, 20};
    vecs[6] = '{5'd7,  1'b0, 16'h0107, 1};

    idle_inputs();
    areset = 1;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_ctrl", {busy, done, cfg_err, s_axis_tready, fft_cfg_tvalid, ifft_cfg_tvalid,
                       sig_tvalid, sf_tvalid, sig_tlast}, 9'd0);
    check("rst_data", {fft_cfg_tdata, ifft_cfg_tdata, sig_tdata, sf_tdata}, '0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge aclk);
    areset = 0;

    load_ram(1);

    foreach (vecs[i]) begin
      sc = SCALE_W'($urandom);
      @(negedge aclk);
      cfg_start = 1; cfg_log2n = vecs[i].l2n; cfg_scale = sc; cfg_frames = 1;
      @(negedge aclk);
      cfg_start = 0;
      #1;
      check("start_err", cfg_err, vecs[i].exp_err);
      check("start_busy", busy, !vecs[i].exp_err);
      if (vecs[i].exp_err) begin
        @(negedge aclk);
        #1 check("err_one_cycle", {cfg_err, busy}, 2'b00);
      end else begin
        for (int c = 0; c < vecs[i].hold; c++) begin
          @(negedge aclk);
          #1 check("fft_hold", {fft_cfg_tvalid, ifft_cfg_tvalid, fft_cfg_tdata},
                   {1'b1, 1'b0, vecs[i].exp_fft});
        end
        fft_cfg_tready = 1;
        @(negedge aclk);
        fft_cfg_tready = 0;
        #1 check("ifft_word_tbl", {fft_cfg_tvalid, ifft_cfg_tvalid, ifft_cfg_tdata},
                 {1'b0, 1'b1, (24'(sc) << 9) | 24'(vecs[i].l2n)});
        ifft_cfg_tready = 1;
        @(negedge aclk);
        ifft_cfg_tready = 0;
        #1 check("stream_entry", {busy, fft_cfg_tvalid, ifft_cfg_tvalid, s_axis_tready}, 4'b1001);
        pulse_reset();
      end
    end

    // Single 8-sample frame at full rate over a ramp reference.
    foreach (fr_data[i]) fr_data[i] = DW2'($urandom);
    @(negedge aclk);
    cfg_start = 1; cfg_log2n = 3; cfg_frames = 1; cfg_scale = SCALE_W'($urandom);
    fft_cfg_tready = 1; ifft_cfg_tready = 1; sig_tready = 1; sf_tready = 1;
    @(negedge aclk);
    cfg_start = 0;
    repeat (2) @(negedge aclk);
    s_axis_tvalid = 1; s_axis_tdata = fr_data[0];
    #1 check("fr_first_ready", s_axis_tready, 1);
    for (int b = 0; b < 8; b++) begin
      @(negedge aclk);
      if (b < 7) s_axis_tdata = fr_data[b + 1];
      else       s_axis_tvalid = 0;
      #1 check("fr_beat", {sig_tvalid, sf_tvalid, sig_tlast, sf_tdata, sig_tdata},
               {1'b1, 1'b1, b == 7, DW2'(b), fr_data[b]});
    end
    @(negedge aclk);
    #1 check("fr_done", {done, frame_cnt}, {1'b1, 16'd1});
    @(negedge aclk);
    #1 check("fr_idle", {done, busy}, 2'b00);
    idle_inputs();

    load_ram(0);

    // Reset partway through a frame, then restart cleanly from k=0.
    @(negedge aclk);
    cfg_start = 1; cfg_log2n = 3; cfg_frames = 1;
    fft_cfg_tready = 1; ifft_cfg_tready = 1; sig_tready = 1; sf_tready = 1;
    @(negedge aclk);
    cfg_start = 0;
    repeat (2) @(negedge aclk);
    s_axis_tvalid = 1; s_axis_tdata = DW2'($urandom);
    for (int b = 0; b < 6; b++) begin
      @(negedge aclk);
      s_axis_tdata = DW2'($urandom);
    end
    #1 areset = 1;
    #1;
    check("midrst_ctrl", {busy, done, cfg_err, s_axis_tready, fft_cfg_tvalid, ifft_cfg_tvalid,
                          sig_tvalid, sf_tvalid, sig_tlast}, 9'd0);
    check("midrst_data", {fft_cfg_tdata, ifft_cfg_tdata, sig_tdata, sf_tdata, frame_cnt}, '0);
    idle_inputs();
    @(negedge aclk);
    areset = 0;
    run_stream(5'd3, 16'd2, 0, 90, 80);

    run_stream(5'd4, 16'd0, 3, 80, 60);
    run_stream(5'd5, 16'd2, 0, 70, 50);
    run_stream(5'd6, 16'd3, 0, 100, 100);
    run_stream(5'd4, 16'd0, 2, 100, 100);
    run_stream(5'd10, 16'd1, 0, 90, 70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/correl_frame_sequencer.md
Name: correl_frame_sequencer

Overview:
- Feeds the FFT-based pulse-compression correlator: issues the FFT and IFFT config words, then streams received samples and the matching reference-function samples to the correlator in frame lockstep, generating tlast.
- Generalises the single-frame, fixed-1024, tready-blind stimulus of the current correlator flow: runtime FFT length, N-frame or continuous mode, full AXI-Stream backpressure on every channel.
- Sits between the ADC/sample source and the correlator block design's S_AXIS_RE/IM, SF_RE/IM and FFT/IFFT_CONFIG ports.

Parameters:
- DATA_W, 16, width of each I and Q component.
- MAX_LOG2, 10, largest log2 FFT length; reference RAM depth is 2^MAX_LOG2.
- MIN_LOG2, 3, smallest accepted log2 FFT length.
- SCALE_W, 14, width of the IFFT scale schedule.
- FRM_W, 16, width of the frame counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  async active-high reset.
- cfg_start  in  1  start pulse; ignored unless in IDLE.
- cfg_stop  in  1  continuous mode only: end the run at the next frame boundary.
- cfg_log2n  in  5  log2 FFT length, sampled at start.
- cfg_scale  in  SCALE_W  IFFT scale schedule, sampled at start.
- cfg_frames  in  FRM_W  frame count; 0 selects continuous mode.
- ref_wr_en  in  1  reference RAM write strobe.
- ref_wr_addr  in  MAX_LOG2  reference RAM write address.
- ref_wr_data  in  2*DATA_W  reference sample {Q,I}.
- s_axis_tdata  in  2*DATA_W  received sample {Q,I}.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- fft_cfg_tdata  out  16  FFT config word.
- fft_cfg_tvalid  out  1  FFT config valid.
- fft_cfg_tready  in  1  FFT config ready.
- ifft_cfg_tdata  out  24  IFFT config word.
- ifft_cfg_tvalid  out  1  IFFT config valid.
- ifft_cfg_tready  in  1  IFFT config ready.
- sig_tdata  out  2*DATA_W  received-sample stream to the correlator.
- sig_tvalid  out  1  received-sample valid.
- sig_tlast  out  1  last sample of the frame.
- sig_tready  in  1  received-sample ready.
- sf_tdata  out  2*DATA_W  reference stream to the correlator.
- sf_tvalid  out  1  reference valid.
- sf_tready  in  1  reference ready.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- frame_cnt  out  FRM_W  number of completed frames.

Behaviour:
- Reset: every output 0, state IDLE, all counters 0, flags clear. Reset mid-run aborts immediately; RAM contents are retained.
- FSM states:
  - IDLE: on cfg_start, latch config. If cfg_log2n is outside [MIN_LOG2, MAX_LOG2], pulse cfg_err and stay in IDLE. Otherwise go to CFG_FFT.
  - CFG_FFT: drive fft_cfg_tdata = {7'b0, fwd=1, 3'b0, log2n} with tvalid held until fft_cfg_tready, then go to CFG_IFFT.
  - CFG_IFFT: drive ifft_cfg_tdata = {pad, scale[SCALE_W-1:0], fwd=0, 3'b0, log2n} with tvalid held until ifft_cfg_tready, then go to STREAM.
  - STREAM: run frames of N = 2^log2n samples. Sample index k runs 0..N-1 and wraps to 0 at each frame.
  - DONE: one cycle, done=1, then IDLE.
- Output slot: a single registered slot shared by sig and sf.
  - On an s_axis handshake, the slot is loaded with the sample into sig_tdata and ref RAM[k] into sf_tdata through the RAM's registered read.
  - sig_tvalid and sf_tvalid rise together one cycle after the upstream handshake.
  - sig_tlast = (k == N-1) for the loaded sample.
- Lockstep rule:
  - Each valid is held until its own handshake, tracked by per-channel accepted flags.
  - The slot empties when both channels are accepted; acceptance may occur in the same cycle or in different cycles.
  - Valids never depend on ready.
- s_axis_tready = STREAM && samples remaining in frame && (slot empty || both channels complete this cycle). This gives 1 sample/cycle when both downstream readies are high.
- Frame end: the last sample's dual acceptance increments frame_cnt.
  - Finite mode: frame_cnt == cfg_frames goes to DONE.
  - Continuous mode: a stop request (cfg_stop seen at any time during the frame) goes to DONE; otherwise the next frame starts with no config reissue and no bubble.
- Writes to ref RAM are accepted only in IDLE; they are ignored while busy.
- cfg_start while busy is ignored.

Decomposition:
- Package correl_seq_pkg holds:
  - the state enum;
  - config field offsets (NFFT_LSB=0, FWD_BIT=8, SCALE_LSB=9);
  - FWD/INV constants.
- One sub-module, correl_ref_ram: simple dual-port RAM, 2^MAX_LOG2 x 2*DATA_W, synchronous write, registered read with read enable.

Test Plan:
- Reject and accept start:
  - cfg_log2n=2 with MIN_LOG2=3 → cfg_err pulse, busy stays 0.
  - cfg_log2n=10 → fft_cfg_tdata=16'h010A, then ifft_cfg_tdata with bits[7:0]=0x0A, bit8=0, scale at [22:9].
- Config backpressure: hold fft_cfg_tready=0 for 20 cycles → tvalid and tdata stable throughout; ifft_cfg_tvalid stays 0 until after the fft handshake.
- Single frame at full rate: ramp RAM (ref[k]=k), log2n=3, frames=1, all readies high.
  - 8 consecutive beats; sf_tdata=k aligned with sig.
  - sig_tlast only on beat 8.
  - done 1 cycle after the final accept; frame_cnt=1.
- Skewed readies: random sf_tready and sig_tready → no duplicated or lost samples; sf_tdata and sig_tdata pairings match the ref[k]/sample[k] pairs; tvalid never drops before its handshake.
- Continuous mode: frames=0, log2n=4, cfg_stop pulsed mid frame 3 → frames complete exactly at frame_cnt=3, then done; ref index wraps to 0 at each frame.
- Reset mid-frame: assert areset at k=5 → all outputs 0 immediately; a restart produces correct frame data from k=0.
